sram_rmw_ctrl: RTL and testbench

- Parametrised controller in front of one single-port OpenRAM RW macro (active-low csb0/web0, one-cycle registered read).
- Serves read, write, accumulate (read-modify-write: mem[a] <= mem[a] + data) and clear requests over a valid/ready request port and a valid-only response port.
- Zero-fills the array after reset.
- Generalises the fixed 512x8 dout+din wrapper: any width and depth, a sequenced RMW path, and saturating/wrapping modes.

---
 rtl/sram_rmw_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_sram_rmw_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rmw_ctrl.sv
// Request controller for a single-port OpenRAM RW macro: read, write, read-modify-write
// accumulate and clear-all, with a zero-fill sweep after reset.
module sram_rmw_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 9,
  parameter bit SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_data_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_ovf_o,
  output logic          init_done_o,
  output logic          sram_csb0_o,
  output logic          sram_web0_o,
  output logic [AW-1:0] sram_addr0_o,
  output logic [DW-1:0] sram_din0_o,
  input  logic [DW-1:0] sram_dout0_i
);

  localparam logic [2:0] S_CLEAR    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_RD_CMD   = 3'd2;
  localparam logic [2:0] S_RD_DATA  = 3'd3;
  localparam logic [2:0] S_WR_CMD   = 3'd4;
  localparam logic [2:0] S_ACC_CMD  = 3'd5;
  localparam logic [2:0] S_ACC_DATA = 3'd6;
  localparam logic [2:0] S_ACC_WR   = 3'd7;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [2:0]    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] addend_q, addend_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          acc_ovf_q, acc_ovf_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic          init_done_q, init_done_d;
  logic          csb_q, csb_d;
  logic          web_q, web_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;

  logic          accept;
  logic [DW:0]   sum;
  logic [DW-1:0] stored;

  // ready is only ever high in IDLE, so this is the whole accept condition
  assign accept = req_valid_i && ready_q;
  assign sum    = {1'b0, sram_dout0_i} + {1'b0, addend_q};
  assign stored = (sum[DW] && SATURATE) ? {DW{1'b1}} : sum[DW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addend_d    = addend_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    init_done_d = init_done_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    addr_d      = addr_q;
    din_d       = din_q;
    case (state_q)
      S_CLEAR: begin
        // counter MSB marks that all DEPTH words have been issued
        if (cnt_q[AW]) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          ready_d     = 1'b1;
        end else begin
          csb_d  = 1'b0;
          web_d  = 1'b0;
          addr_d = cnt_q[AW-1:0];
          din_d  = '0;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_IDLE: begin
        ready_d = !accept;
        if (accept) begin
          addend_d = req_data_i;
          case (req_op_i)
            OP_RD: begin
              csb_d   = 1'b0;
              addr_d  = req_addr_i;
              state_d = S_RD_CMD;
            end
            OP_WR: begin
              csb_d   = 1'b0;
              web_d   = 1'b0;
              addr_d  = req_addr_i;
              din_d   = req_data_i;
              state_d = S_WR_CMD;
            end
            OP_ACC: begin
              csb_d   = 1'b0;
              addr_d  = req_addr_i;
              state_d = S_ACC_CMD;
            end
            default: begin
              cnt_d       = '0;
              init_done_d = 1'b0;
              state_d     = S_CLEAR;
            end
          endcase
        end
      end
      S_RD_CMD:  state_d = S_RD_DATA;
      S_RD_DATA: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = sram_dout0_i;
        rsp_ovf_d   = 1'b0;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      S_WR_CMD: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      S_ACC_CMD: state_d = S_ACC_DATA;
      S_ACC_DATA: begin
        csb_d     = 1'b0;
        web_d     = 1'b0;
        din_d     = stored;
        acc_d     = stored;
        acc_ovf_d = sum[DW];
        state_d   = S_ACC_WR;
      end
      S_ACC_WR: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = acc_q;
        rsp_ovf_d   = acc_ovf_q;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        cnt_d       = '0;
        init_done_d = 1'b0;
        state_d     = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      addend_q    <= '0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      init_done_q <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addend_q    <= addend_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      init_done_q <= init_done_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_ovf_o    = rsp_ovf_q;
  assign init_done_o  = init_done_q;
  assign sram_csb0_o  = csb_q;
  assign sram_web0_o  = web_q;
  assign sram_addr0_o = addr_q;
  assign sram_din0_o  = din_q;

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Directed bench: two controllers (saturating / wrapping) share one stimulus stream,
// each backed by its own behavioural single-port macro.
module tb_sram_rmw_ctrl;
  localparam int DW = 8;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;

  logic [1:0] rdy, rv, rovf, init, csb, web;
  logic [1:0][DW-1:0] rdata, din;
  logic [1:0][AW-1:0] addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [512];
    logic [DW-1:0] dout;

    initial begin
      dout = '0;
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(1, 255));
    end

    always @(posedge clk) begin
      if (!csb[g]) begin
        if (!web[g]) mem[addr[g]] <= din[g];
        else         dout <= mem[addr[g]];
      end
    end

    sram_rmw_ctrl #(.DW(DW), .AW(AW), .SATURATE(g == 0)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (rdy[g]),
      .req_op_i     (req_op),
      .req_addr_i   (req_addr),
      .req_data_i   (req_data),
      .rsp_valid_o  (rv[g]),
      .rsp_data_o   (rdata[g]),
      .rsp_ovf_o    (rovf[g]),
      .init_done_o  (init[g]),
      .sram_csb0_o  (csb[g]),
      .sram_web0_o  (web[g]),
      .sram_addr0_o (addr[g]),
      .sram_din0_o  (din[g]),
      .sram_dout0_i (dout)
    );
  end

  // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    while (rdy[0] !== 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (rdy[0] !== 1'b1) begin
      tests++; fails++;
      $display("FAIL issue_timeout: req_ready=%b after %0d cycles, want 1", rdy[0], n);
    end
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00; req_addr = '1; req_data = 8'hAA;
  endtask

  // Watches a clear sweep until init_done rises; reports command count and anomalies.
  task automatic sweep_watch(output int ncmd, output int nbad, output bit tout, output bit prev_cmd);
    ncmd = 0; nbad = 0; tout = 1'b1; prev_cmd = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (init === 2'b11) begin
        tout = 1'b0;
        break;
      end
      if (rv !== 2'b00 || csb[0] !== csb[1]) nbad++;
      prev_cmd = 1'b0;
      if (csb[0] === 1'b0) begin
        if (web !== 2'b00 || addr[0] !== AW'(ncmd) || addr[1] !== AW'(ncmd) || din !== '0) nbad++;
        ncmd++;
        prev_cmd = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    int ncmd, nbad; bit tout, prev;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (rdy !== 2'b00)  begin fails++; $display("FAIL reset_ready: got %b want 00", rdy); end
    tests++; if (rv !== 2'b00)   begin fails++; $display("FAIL reset_rsp_valid: got %b want 00", rv); end
    tests++; if (rdata !== '0 || rovf !== 2'b00) begin fails++; $display("FAIL reset_rsp: data %h ovf %b want 0", rdata, rovf); end
    tests++; if (init !== 2'b00) begin fails++; $display("FAIL reset_init_done: got %b want 00", init); end
    tests++; if (csb !== 2'b11 || web !== 2'b11) begin fails++; $display("FAIL reset_csb_web: got %b/%b want 11/11", csb, web); end
    tests++; if (addr !== '0 || din !== '0) begin fails++; $display("FAIL reset_addr_din: got %h/%h want 0", addr, din); end
    rst = 1'b0;
    sweep_watch(ncmd, nbad, tout, prev);
    tests++; if (tout)         begin fails++; $display("FAIL sweep_timeout: init_done never rose"); end
    tests++; if (ncmd != 512)  begin fails++; $display("FAIL sweep_count: got %0d want 512", ncmd); end
    tests++; if (nbad != 0)    begin fails++; $display("FAIL sweep_cmds: %0d bad cycles want 0", nbad); end
    tests++; if (!prev)        begin fails++; $display("FAIL sweep_done_timing: init_done late, want cycle after last cmd"); end
    tests++; if (rdy !== 2'b11 || csb !== 2'b11) begin fails++; $display("FAIL sweep_idle: ready %b csb %b want 11/11", rdy, csb); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    issue(2'b01, 9'h1A5, 8'h3C);
    tests++; if (csb !== 2'b00 || web !== 2'b00 || addr[0] !== 9'h1A5 || din[0] !== 8'h3C || din[1] !== 8'h3C)
      begin fails++; $display("FAIL wr_cmd: csb %b web %b addr %h din %h want 00 00 1a5 3c", csb, web, addr[0], din); end
    tests++; if (rdy !== 2'b00) begin fails++; $display("FAIL wr_busy_ready: got %b want 00", rdy); end
    @(negedge clk);
    tests++; if (csb !== 2'b11 || rdy !== 2'b11 || addr[0] !== 9'h1A5)
      begin fails++; $display("FAIL wr_idle: csb %b ready %b addr %h want 11 11 1a5", csb, rdy, addr[0]); end
    issue(2'b00, 9'h1A5, 8'h00);
    tests++; if (csb !== 2'b00 || web !== 2'b11 || addr[1] !== 9'h1A5)
      begin fails++; $display("FAIL rd_cmd: csb %b web %b addr %h want 00 11 1a5", csb, web, addr[1]); end
    @(negedge clk);
    tests++; if (rv !== 2'b00 || rdy !== 2'b00) begin fails++; $display("FAIL rd_early: valid %b ready %b want 00/00", rv, rdy); end
    @(negedge clk);
    tests++; if (rv !== 2'b11 || rdata[0] !== 8'h3C || rdata[1] !== 8'h3C || rovf !== 2'b00)
      begin fails++; $display("FAIL rd_rsp: valid %b data %h ovf %b want 11 3c3c 00", rv, rdata, rovf); end
    @(negedge clk);
    tests++; if (rv !== 2'b00 || rdata[0] !== 8'h3C) begin fails++; $display("FAIL rd_pulse_hold: valid %b data %h want 00 3c", rv, rdata[0]); end
  endtask

  task automatic test_accumulate();
    @(negedge clk);
    issue(2'b01, 9'h007, 8'hF0);
    @(negedge clk);
    issue(2'b10, 9'h007, 8'h20);
    tests++; if (rv !== 2'b00 || csb !== 2'b00 || web !== 2'b11)
      begin fails++; $display("FAIL acc_cmd: valid %b csb %b web %b want 00 00 11", rv, csb, web); end
    @(negedge clk);
    @(negedge clk);
    tests++; if (csb !== 2'b00 || web !== 2'b00 || addr[0] !== 9'h007 || din[0] !== 8'hFF || din[1] !== 8'h10 || rv !== 2'b00)
      begin fails++; $display("FAIL acc_wr: csb %b web %b addr %h din %h valid %b want 00 00 007 ff/10 00", csb, web, addr[0], din, rv); end
    @(negedge clk);
    tests++; if (rv !== 2'b11 || rdata[0] !== 8'hFF || rovf[0] !== 1'b1)
      begin fails++; $display("FAIL acc_sat: valid %b data %h ovf %b want 1 ff 1", rv[0], rdata[0], rovf[0]); end
    tests++; if (rv[1] !== 1'b1 || rdata[1] !== 8'h10 || rovf[1] !== 1'b1)
      begin fails++; $display("FAIL acc_wrap: valid %b data %h ovf %b want 1 10 1", rv[1], rdata[1], rovf[1]); end
    issue(2'b00, 9'h007, 8'h00);
    @(negedge clk);
    @(negedge clk);
    tests++; if (rv !== 2'b11 || rdata[0] !== 8'hFF || rdata[1] !== 8'h10 || rovf !== 2'b00)
      begin fails++; $display("FAIL acc_readback: valid %b data %h ovf %b want 11 ff/10 00", rv, rdata, rovf); end
    issue(2'b10, 9'h007, 8'h05);
    repeat (3) @(negedge clk);
    tests++; if (rv !== 2'b11 || rdata[0] !== 8'hFF || rovf[0] !== 1'b1 || rdata[1] !== 8'h15 || rovf[1] !== 1'b0)
      begin fails++; $display("FAIL acc_second: data %h ovf %b want ff/15 ovf 1/0", rdata, rovf); end
  endtask

  task automatic test_back_to_back();
    int acc_c[3], rsp_c[3];
    logic [DW-1:0] rd0[3], rd1[3];
    int na, nr;
    na = 0; nr = 0;
    for (int i = 0; i < 3; i++) begin acc_c[i] = -100; rsp_c[i] = -100; rd0[i] = '0; rd1[i] = '0; end
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 9'h003; req_data = 8'h01;
    for (int c = 0; c < 30; c++) begin
      if (rv[0] === 1'b1) begin
        if (nr < 3) begin rsp_c[nr] = c; rd0[nr] = rdata[0]; rd1[nr] = rdata[1]; end
        nr++;
      end
      if (rdy[0] === 1'b1 && req_valid) begin
        if (na < 3) acc_c[na] = c;
        na++;
      end
      @(negedge clk);
      if (na >= 3) req_valid = 1'b0;
    end
    tests++; if (na != 3 || nr != 3) begin fails++; $display("FAIL b2b_counts: accepts %0d rsps %0d want 3/3", na, nr); end
    tests++; if (acc_c[1] - acc_c[0] != 4 || acc_c[2] - acc_c[1] != 4)
      begin fails++; $display("FAIL b2b_spacing: accept cycles %0d %0d %0d want 4 apart", acc_c[0], acc_c[1], acc_c[2]); end
    tests++; if (rsp_c[0] != acc_c[0] + 4 || rsp_c[1] != acc_c[1] + 4 || rsp_c[2] != acc_c[2] + 4)
      begin fails++; $display("FAIL b2b_latency: rsp cycles %0d %0d %0d want accept+4", rsp_c[0], rsp_c[1], rsp_c[2]); end
    tests++; if (rd0[0] !== 8'd1 || rd0[1] !== 8'd2 || rd0[2] !== 8'd3 || rd1[0] !== 8'd1 || rd1[1] !== 8'd2 || rd1[2] !== 8'd3)
      begin fails++; $display("FAIL b2b_data: got %h %h %h / %h %h %h want 01 02 03", rd0[0], rd0[1], rd0[2], rd1[0], rd1[1], rd1[2]); end
  endtask

  task automatic test_reset_mid_rmw();
    int ncmd, nbad; bit tout, prev;
    logic [AW-1:0] ra [4];
    ra[0] = 9'h055; ra[1] = 9'h1A5; ra[2] = 9'h007; ra[3] = 9'h003;
    @(negedge clk);
    issue(2'b10, 9'h055, 8'h11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (csb !== 2'b11 || rv !== 2'b00 || rdy !== 2'b00 || init !== 2'b00)
      begin fails++; $display("FAIL midrst_state: csb %b valid %b ready %b init %b want 11 00 00 00", csb, rv, rdy, init); end
    rst = 1'b0;
    sweep_watch(ncmd, nbad, tout, prev);
    tests++; if (tout || ncmd != 512 || nbad != 0)
      begin fails++; $display("FAIL midrst_sweep: timeout %b cmds %0d bad %0d want 0 512 0", tout, ncmd, nbad); end
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, ra[i], 8'h00);
      @(negedge clk);
      @(negedge clk);
      tests++; if (rv !== 2'b11 || rdata !== '0)
        begin fails++; $display("FAIL midrst_read_%h: valid %b data %h want 11 0000", ra[i], rv, rdata); end
    end
  endtask

  task automatic test_clear_op();
    int ncmd, nbad; bit tout, prev;
    @(negedge clk);
    issue(2'b01, 9'h010, 8'h77);
    @(negedge clk);
    issue(2'b11, 9'h000, 8'h00);
    tests++; if (init !== 2'b00 || rdy !== 2'b00 || csb !== 2'b11)
      begin fails++; $display("FAIL clr_start: init %b ready %b csb %b want 00 00 11", init, rdy, csb); end
    sweep_watch(ncmd, nbad, tout, prev);
    tests++; if (tout || ncmd != 512 || nbad != 0 || !prev)
      begin fails++; $display("FAIL clr_sweep: timeout %b cmds %0d bad %0d done_next %b want 0 512 0 1", tout, ncmd, nbad, prev); end
    issue(2'b00, 9'h010, 8'h00);
    @(negedge clk);
    @(negedge clk);
    tests++; if (rv !== 2'b11 || rdata !== '0)
      begin fails++; $display("FAIL clr_read: valid %b data %h want 11 0000", rv, rdata); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_accumulate();
    test_back_to_back();
    test_reset_mid_rmw();
    test_clear_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
